// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared types for the I2C byte-level controller.
//   cmd_op_e  - command codes carried on cmd_op
//   state_e   - controller FSM states
//   CNT_W     - width of the quarter-period counter (CLK_DIV up to 65535)
//   op_legal  - whether a command may run given current bus ownership
package i2c_ctrl_pkg;

    typedef enum logic [2:0] {
        START = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        STOP  = 3'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE, START_A, START_B, BIT, ACK, STOP_A, STOP_B, DONE
    } state_e;

    localparam int CNT_W = 16;

    // START is always allowed (repeated start when owned); data and STOP
    // commands need an owned bus; codes 4..7 are never legal.
    function automatic logic op_legal(input logic [2:0] op, input logic owned);
        case (op)
            START:             op_legal = 1'b1;
            WRITE, READ, STOP: op_legal = owned;
            default:           op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: SCL quarter-period divider.
//   clk, start_rst - clock, async active-high reset
//   run            - count while a command is executing, else held at 0
//   clr            - command accepted: restart from 0
//   hold           - keep the counter parked at 0 (target clock stretching)
//   tick           - one-cycle pulse on the last count of each quarter
module i2c_qtick
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic start_rst,
    input  logic run,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = run && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst)
            cnt_q <= '0;
        else if (clr || !run)
            cnt_q <= '0;
        else if (hold && cnt_q == '0)
            cnt_q <= '0;
        else if (cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: byte-level I2C master (START / WRITE / READ / STOP).
//   clk, start_rst          - clock, async active-high reset
//   cmd_valid/ready         - command handshake; cmd_op, cmd_wdata, cmd_mack
//   rsp_valid               - one-cycle completion pulse with rsp_rdata,
//                             rsp_nack (WRITE not acknowledged), rsp_err
//   bus_owned               - START done, STOP not yet finished
//   scl_i, sda_i            - synchronised bus lines
//   scl_oe, sda_oe          - open-drain pull-downs (1 = drive low)
// Build option: I2C_CLK_STRETCH_EN makes released-SCL quarters wait for
// scl_i high before counting (target clock stretching).
module i2c_controller
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       start_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_mack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       bus_owned,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    state_e     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] op_q;
    logic [7:0] wdata_q, rx_sr;
    logic       mack_q, err_q, ack_smp, sda_last, out_en;
    logic       accept, tick, active, hold, smp;

    // out_en keeps cmd_ready low until the first edge after reset.
    assign cmd_ready = out_en && (state_q == IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign active    = (state_q != IDLE) && (state_q != DONE);
    assign smp       = tick && (qtr_q == 2'd1);

`ifdef I2C_CLK_STRETCH_EN
    assign hold = active && !scl_oe && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk       (clk),
        .start_rst (start_rst),
        .run       (active),
        .clr       (accept),
        .hold      (hold),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            state_q <= IDLE;
            qtr_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        // Between commands: SCL low while owned, SDA parked where it was.
        scl_oe  = bus_owned;
        sda_oe  = sda_last;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    qtr_d = '0;
                    bit_d = 3'd7;
                    if (!op_legal(cmd_op, bus_owned))
                        state_d = DONE;
                    else begin
                        case (cmd_op)
                            START:   state_d = START_A;
                            STOP:    state_d = STOP_A;
                            default: state_d = BIT;
                        endcase
                    end
                end
            end
            START_A: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
                if (tick) state_d = START_B;
            end
            START_B: begin
                // q0: SDA falls with SCL high; q1: SCL pulled low
                scl_oe = qtr_q[0];
                sda_oe = 1'b1;
                if (tick) begin
                    if (qtr_q[0]) state_d = DONE;
                    else          qtr_d   = qtr_q + 2'd1;
                end
            end
            BIT: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe = (op_q == WRITE) ? !wdata_q[bit_q] : 1'b0;
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd0) state_d = ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                end
            end
            ACK: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe = (op_q == READ) && mack_q;
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) state_d = DONE;
                end
            end
            STOP_A: begin
                scl_oe = 1'b1;
                sda_oe = 1'b1;
                if (tick) state_d = STOP_B;
            end
            STOP_B: begin
                // q0: SCL released with SDA low; q1: SDA rises (stop)
                scl_oe = 1'b0;
                sda_oe = !qtr_q[0];
                if (tick) begin
                    if (qtr_q[0]) state_d = DONE;
                    else          qtr_d   = qtr_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            out_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
            rsp_err   <= 1'b0;
            bus_owned <= 1'b0;
            sda_last  <= 1'b0;
            op_q      <= '0;
            wdata_q   <= '0;
            mack_q    <= 1'b0;
            err_q     <= 1'b0;
            rx_sr     <= '0;
            ack_smp   <= 1'b0;
        end else begin
            out_en    <= 1'b1;
            rsp_valid <= (state_q == DONE);
            if (active) sda_last <= sda_oe;
            if (accept) begin
                op_q    <= cmd_op;
                wdata_q <= cmd_wdata;
                mack_q  <= cmd_mack;
                err_q   <= !op_legal(cmd_op, bus_owned);
                if (cmd_op == START) bus_owned <= 1'b1;
            end
            if (state_q == STOP_B && tick && qtr_q[0]) bus_owned <= 1'b0;
            if (smp && state_q == BIT) rx_sr   <= {rx_sr[6:0], sda_i};
            if (smp && state_q == ACK) ack_smp <= sda_i;
            // Response fields land together with the rsp_valid pulse.
            if (state_q == DONE) begin
                rsp_err  <= err_q;
                rsp_nack <= !err_q && (op_q == WRITE) && ack_smp;
                if (!err_q && op_q == READ) rsp_rdata <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: random traffic against an I2C register-file target
// (address 7'h55, first written byte sets the register pointer).
`timescale 1ns/1ps
module tb_i2c_controller;
    import i2c_ctrl_pkg::*;

    localparam int         DIV = 4;
    localparam int         LAT = 36 * DIV + 2;
    localparam logic [6:0] TGT = 7'h55;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STR_DLY = 20;
`else
    localparam int STR_DLY = 0;
`endif

    logic       clk = 1'b0;
    logic       start_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_mack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_owned;
    logic [7:0] rsp_rdata;
    logic       scl_oe, sda_oe, scl_i, sda_i;
    logic       tgt_drv = 1'b0;
    logic       stretch = 1'b0;

    assign scl_i = !scl_oe && !stretch;
    assign sda_i = !sda_oe && !tgt_drv;

    always #5 clk = ~clk;

    i2c_controller #(.CLK_DIV(DIV)) dut (
        .clk       (clk),
        .start_rst (start_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .cmd_mack  (cmd_mack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .rsp_err   (rsp_err),
        .bus_owned (bus_owned),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- target model (bus-level, sampled on negedge) ----------
    logic [7:0] t_mem [256];
    logic [7:0] sh, tx, ptr;
    logic       p_scl, p_sda, s_scl, s_sda, sel, rw, tx_mode, mack_seen, ack9_oe;
    logic       str_arm = 1'b0;
    logic       str_used = 1'b0;
    int         bitn, byten, str_cnt;
    int         stop_cnt = 0;

    initial begin : target
        for (int i = 0; i < 256; i++) t_mem[i] = 8'h00;
        t_mem[5] = 8'hAA;
        p_scl = 1'b1; p_sda = 1'b1; bitn = 0; byten = 0; sel = 1'b0; rw = 1'b0;
        tx_mode = 1'b0; mack_seen = 1'b0; ack9_oe = 1'b0; ptr = 8'h00;
        sh = 8'h00; tx = 8'h00; str_cnt = 0;
        forever begin
            @(negedge clk);
            s_scl = scl_i;
            s_sda = sda_i;
            if (start_rst) begin
                bitn = 0; byten = 0; sel = 1'b0; tx_mode = 1'b0; tgt_drv = 1'b0; stretch = 1'b0;
            end else if (p_scl && s_scl && p_sda && !s_sda) begin
                bitn = -1; byten = 0; sel = 1'b0; tx_mode = 1'b0; tgt_drv = 1'b0;
            end else if (p_scl && s_scl && !p_sda && s_sda) begin
                sel = 1'b0; tx_mode = 1'b0; tgt_drv = 1'b0; stop_cnt++;
            end else if (!p_scl && s_scl) begin
                if (bitn < 8) sh = {sh[6:0], s_sda};
                else begin mack_seen = !s_sda; ack9_oe = sda_oe; end
            end else if (p_scl && !s_scl) begin
                if (bitn < 7) begin
                    bitn++;
                    if (tx_mode) tgt_drv = !tx[7-bitn];
                end else if (bitn == 7) begin
                    bitn = 8;
                    if (tx_mode) tgt_drv = 1'b0;
                    else if (byten == 0) begin
                        sel = (sh[7:1] == TGT); rw = sh[0]; tgt_drv = sel;
                    end else if (sel && !rw) begin
                        if (byten == 1) ptr = sh;
                        else begin t_mem[ptr] = sh; ptr++; end
                        tgt_drv = 1'b1;
                    end else tgt_drv = 1'b0;
                    if (str_arm && !str_used) begin
                        str_used = 1'b1; stretch = 1'b1; str_cnt = 0;
                    end
                end else begin
                    bitn = 0;
                    tgt_drv = 1'b0;
                    if (byten == 0) tx_mode = sel && rw;
                    else            tx_mode = tx_mode && mack_seen;
                    byten++;
                    if (tx_mode) begin tx = t_mem[ptr]; ptr++; tgt_drv = !tx[7]; end
                end
            end
            p_scl = s_scl;
            p_sda = s_sda;
            // hold SCL low for the first 20 cycles the master releases it
            if (stretch && !scl_oe) begin
                str_cnt++;
                if (str_cnt == 21) stretch = 1'b0;
            end
        end
    end

    // ---------------- command driver ----------------------------------------
    logic [7:0] exp_mem [256];
    int         r_lat;
    logic       r_nack, r_err, r_oe, r_rdy;
    logic [7:0] r_rdata;

    task automatic issue(input logic [2:0] op, input logic [7:0] wd, input logic mk);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; cmd_mack = mk;
        for (int n = 0; n < 200 && !cmd_ready; n++) @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        r_oe = 1'b0; r_lat = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            r_oe = r_oe | scl_oe | sda_oe;
            if (rsp_valid) begin r_lat = n; break; end
        end
        r_nack = rsp_nack; r_err = rsp_err; r_rdata = rsp_rdata; r_rdy = cmd_ready;
        if (r_lat == 0) chk("rsp_timeout", 0, 1);
        chk("rdy_in_rsp", 32'(r_rdy), 0);
        @(negedge clk);
        chk("rsp_pulse", 32'(rsp_valid), 0);
    endtask

    task automatic do_start();
        issue(START, 8'h00, 1'b0); wait_rsp();
        chk("start_err", 32'(r_err), 0);
        chk("start_owned", 32'(bus_owned), 1);
    endtask

    task automatic do_stop();
        int sc;
        sc = stop_cnt;
        issue(STOP, 8'h00, 1'b0); wait_rsp();
        chk("stop_err", 32'(r_err), 0);
        chk("stop_owned", 32'(bus_owned), 0);
        chk("stop_cond", stop_cnt, sc + 1);
    endtask

    task automatic do_wr(input logic [7:0] b, input logic exp_nack);
        issue(WRITE, b, 1'b0); wait_rsp();
        chk("wr_lat", r_lat, LAT);
        chk("wr_nack", 32'(r_nack), 32'(exp_nack));
        chk("wr_err", 32'(r_err), 0);
    endtask

    task automatic do_rd(input logic mk, input logic [7:0] exp_b);
        issue(READ, 8'h00, mk); wait_rsp();
        chk("rd_lat", r_lat, LAT);
        chk("rd_data", 32'(r_rdata), 32'(exp_b));
        chk("rd_err", 32'(r_err), 0);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         nb;
        logic [7:0] p, d;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        exp_mem[5] = 8'hAA;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_scl", 32'(scl_oe), 0);
        chk("rst_sda", 32'(sda_oe), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_owned", 32'(bus_owned), 0);
        chk("rst_nack_err", 32'({rsp_nack, rsp_err}), 0);
        start_rst = 1'b0;
        chk("rel_ready0", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("rel_ready1", 32'(cmd_ready), 1);

        // write to present target, then stop
        do_start(); do_wr(8'hAA, 1'b0); do_wr(8'h05, 1'b0); do_stop();
        // absent address
        do_start(); do_wr(8'hA4, 1'b1); do_stop();
        // pointer write, repeated start, single read with NACK
        do_start(); do_wr(8'hAA, 1'b0); do_wr(8'h05, 1'b0);
        do_start(); do_wr(8'hAB, 1'b0); do_rd(1'b0, exp_mem[5]);
        chk("ack9_released", 32'(ack9_oe), 0);
        do_stop();

        // illegal commands while the bus is free
        issue(READ, 8'h00, 1'b1); wait_rsp();
        chk("ill_rd_err", 32'(r_err), 1);
        chk("ill_rd_lat", r_lat, 2);
        chk("ill_rd_bus", 32'(r_oe), 0);
        issue(3'(3'd5 + 3'($urandom_range(0, 2))), 8'h00, 1'b0); wait_rsp();
        chk("ill_op_err", 32'(r_err), 1);
        chk("ill_op_lat", r_lat, 2);

        // random write bursts read back through the target
        for (int it = 0; it < 4; it++) begin
            nb = $urandom_range(1, 3);
            p  = 8'($urandom_range(8, 240));
            do_start(); do_wr(8'hAA, 1'b0); do_wr(p, 1'b0);
            for (int i = 0; i < nb; i++) begin
                d = 8'($urandom);
                exp_mem[p + 8'(i)] = d;
                do_wr(d, 1'b0);
            end
            do_start(); do_wr(8'hAA, 1'b0); do_wr(p, 1'b0);
            do_start(); do_wr(8'hAB, 1'b0);
            for (int i = 0; i < nb; i++) do_rd(i < nb - 1, exp_mem[p + 8'(i)]);
            do_stop();
        end

        // reset in bit 3 of a WRITE
        do_start();
        issue(WRITE, 8'h00, 1'b0);
        repeat (50) @(negedge clk);
        chk("pre_rst_scl", 32'(scl_oe), 1);
        chk("pre_rst_sda", 32'(sda_oe), 1);
        start_rst = 1'b1;
        #1;
        chk("mid_rst_scl", 32'(scl_oe), 0);
        chk("mid_rst_sda", 32'(sda_oe), 0);
        chk("mid_rst_owned", 32'(bus_owned), 0);
        repeat (2) @(negedge clk);
        start_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        do_start(); do_stop();

        // target stretches SCL in the address ACK
        do_start();
        str_arm = 1'b1;
        issue(WRITE, 8'hAA, 1'b0); wait_rsp();
        chk("str_lat", r_lat, LAT + STR_DLY);
        chk("str_nack", 32'(r_nack), 0);
        @(negedge clk);
        start_rst = 1'b1;
        repeat (2) @(negedge clk);
        start_rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_controller.md
I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 Parameter CLK_DIV, default 250: system clocks per SCL quarter-period; legal range 4..65535.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 start_rst  input  1  reset; asynchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller accepts command this cycle.
REQ-006 cmd_op  input  3  command code: START, WRITE, READ, STOP.
REQ-007 cmd_wdata  input  8  byte for WRITE, sent MSB first.
REQ-008 cmd_mack  input  1  for READ: 1 = drive master ACK, 0 = drive NACK.
REQ-009 rsp_valid  output  1  one-cycle pulse at command completion.
REQ-010 rsp_rdata  output  8  byte received by READ; holds value until next READ completes.
REQ-011 rsp_nack  output  1  WRITE: target NACKed; valid with rsp_valid.
REQ-012 rsp_err  output  1  illegal command; valid with rsp_valid.
REQ-013 bus_owned  output  1  START issued, STOP not yet completed.
REQ-014 scl_i, sda_i  input  1 each  sampled bus lines, pre-synchronised.
REQ-015 scl_oe, sda_oe  output  1 each  1 = pull line low, 0 = release (open-drain).

Function
REQ-016 Quarter tick: counter counts 0..CLK_DIV-1, pulses tick on wrap; it runs only while a command executes and clears on command acceptance.
REQ-017 Handshake: transfer when cmd_valid && cmd_ready; cmd_ready=1 only in IDLE and never in the rsp_valid cycle.
REQ-018 FSM states: IDLE, START_A, START_B, BIT, ACK, STOP_A, STOP_B, DONE. All phases advance on tick.
REQ-019 START from IDLE: release SDA, release SCL (one quarter), SDA low (one quarter), SCL low (one quarter); bus_owned=1. START while bus_owned produces a repeated start with the same sequence.
REQ-020 BIT phase: 4 quarters. Q0: SCL low, set SDA. Q1/Q2: SCL released. Q3: SCL low. Data sampled from sda_i at end of Q1.
REQ-021 WRITE: 8 bits from cmd_wdata[7..0], then ACK bit with SDA released; rsp_nack = sampled sda_i.
REQ-022 READ: SDA released for 8 bits, shifted MSB first into rsp_rdata; ACK bit drives SDA low if cmd_mack=1, else released.
REQ-023 STOP: SDA low with SCL low (one quarter), release SCL (one quarter), release SDA (one quarter); bus_owned=0.
REQ-024 DONE: rsp_valid=1 for exactly one clk, then IDLE.
REQ-025 Illegal commands (WRITE/READ with bus_owned=0, STOP with bus_owned=0, undefined cmd_op): no bus activity; rsp_err=1 with rsp_valid two clks after acceptance.
REQ-026 Latency, legal WRITE/READ: 36*CLK_DIV + 2 clks from acceptance to rsp_valid when no stretching occurs.
REQ-027 Between commands while bus_owned: SCL held low, SDA held at its last value.

Reset
REQ-028 start_rst asserted: scl_oe=0, sda_oe=0, cmd_ready=0, rsp_valid=0, rsp_nack=0, rsp_err=0, rsp_rdata=8'h00, bus_owned=0, FSM=IDLE, counter=0.
REQ-029 Reset mid-transfer releases both lines immediately and generates no STOP; the first clk after deassertion sets cmd_ready=1.

Configuration
REQ-030 I2C_CLK_STRETCH_EN defined: in any quarter where SCL is released, the tick counter holds at 0 until scl_i=1, which supports target clock stretching.
REQ-031 I2C_CLK_STRETCH_EN undefined: scl_i is ignored and timing is purely counter-driven.

Structure
REQ-032 Package i2c_ctrl_pkg holds the cmd_op enum (START=0, WRITE=1, READ=2, STOP=3) and the FSM state enum.
REQ-033 Sub-module i2c_qtick (quarter-tick divider with stretch hold) is instantiated once.

Verification
REQ-034 CLK_DIV=4; sequence START, WRITE 8'hAA (addr 7'h55, write), WRITE 8'h05, STOP with a target model at 7'h55 -> both rsp_nack=0, bus_owned falls after STOP, and SDA rises while SCL=1.
REQ-035 START, WRITE 8'hA4 (absent addr 7'h52) -> rsp_nack=1.
REQ-036 START, WRITE 8'hAA, WRITE 8'h05, START, WRITE 8'hAB, READ cmd_mack=0 against a model whose reg 5 = 8'hAA -> rsp_rdata=8'hAA, SDA released during the 9th SCL high.
REQ-037 READ with bus_owned=0 -> rsp_err=1, rsp_valid 2 clks after acceptance, scl_oe=sda_oe=0 throughout.
REQ-038 Assert start_rst during bit 3 of a WRITE -> scl_oe=sda_oe=0 in the same cycle, and a new START is accepted after release.
REQ-039 With I2C_CLK_STRETCH_EN defined, the model holds SCL low 20 clks during a WRITE ACK -> rsp_valid is delayed by 20 clks relative to the unstretched run.
